// File: rtl/write_queue_pkg.sv
// write_queue_pkg
//   Helpers and parameter checks shared by the output-side down-converter
//   (write_queue) and the matching input-side up-converter.
//   - clog2_min1 : ceiling log2, never smaller than 1 bit
//   - widths_ok  : legality of a wide/narrow width pair and a buffer depth
package write_queue_pkg;

    // Ceiling log2 with a floor of 1 so that counters and pointers for
    // degenerate sizes (1 entry, 1 slice) still have a real bit.
    function automatic int clog2_min1(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

    // The wide word must split into a whole number of narrow beats and at
    // least one word must be bufferable.
    function automatic bit widths_ok(input int wide_w, input int narrow_w, input int depth);
        return (narrow_w > 0) && (wide_w >= narrow_w) &&
               ((wide_w % narrow_w) == 0) && (depth >= 1);
    endfunction

endpackage

// File: rtl/write_queue_word_fifo.sv
// word_fifo
//   Small synchronous FIFO of full-width words with explicit pointer wrap,
//   so any depth (not only powers of two) works.
//   Ports:
//     clk, reset        clock, asynchronous active-high reset
//     push, push_data   write push_data at the tail (caller ensures !full)
//     pop               drop the head entry (caller ensures !empty)
//     head_data         oldest entry, valid while !empty
//     count             number of stored entries
//     full, empty       count == DEPTH / count == 0
module word_fifo
    import write_queue_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int DEPTH = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                push,
    input  logic [WIDTH-1:0]                    push_data,
    input  logic                                pop,
    output logic [WIDTH-1:0]                    head_data,
    output logic [clog2_min1(DEPTH + 1)-1:0]    count,
    output logic                                full,
    output logic                                empty
);

    localparam int PTR_W = clog2_min1(DEPTH);
    localparam int CNT_W = clog2_min1(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (push) begin
            mem_d[tail_q] = push_data;
            tail_d = (tail_q == PTR_W'(DEPTH - 1)) ? '0 : tail_q + PTR_W'(1);
        end
        if (pop) begin
            head_d = (head_q == PTR_W'(DEPTH - 1)) ? '0 : head_q + PTR_W'(1);
        end

        // A push and a pop in the same cycle leave the occupancy unchanged.
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_data = mem_q[head_q];
    assign count     = count_q;
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);

endmodule

// File: rtl/write_queue.sv
// write_queue
//   Width down-converter from a kernel's wide output stream to the narrow
//   leaf payload. Each accepted IN_WIDTH word is buffered, then emitted as
//   IN_WIDTH/OUT_WIDTH beats, least-significant slice first.
//   Ports:
//     clk, reset            clock, asynchronous active-high reset
//     din, vld_in           wide word from the kernel and its valid
//     rdy_upward            block can take din this cycle
//     dout, vld_out         narrow beat to the leaf and its valid
//     rdy_downward          leaf takes dout this cycle
//     ap_start              page start; the block stays idle until seen once
//   Handshake: a transfer happens on a rising edge where valid && ready on
//   the same side; valid never depends on ready, rdy_upward depends only on
//   registered state, and an offered beat holds until it is taken.
module write_queue
    import write_queue_pkg::*;
#(
    parameter int IN_WIDTH   = 128,
    parameter int OUT_WIDTH  = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IN_WIDTH-1:0]  din,
    input  logic                 vld_in,
    output logic                 rdy_upward,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 vld_out,
    input  logic                 rdy_downward,
    input  logic                 ap_start
);

    localparam int R       = IN_WIDTH / OUT_WIDTH;
    localparam int SLICE_W = clog2_min1(R);
    localparam int CNT_W   = clog2_min1(FIFO_DEPTH + 1);

    if (!widths_ok(IN_WIDTH, OUT_WIDTH, FIFO_DEPTH)) begin : g_bad_params
        $error("write_queue: IN_WIDTH must be a multiple of OUT_WIDTH and FIFO_DEPTH >= 1");
    end

    logic                 started_q, started_d;
    logic [SLICE_W-1:0]   slice_q, slice_d;

    logic                 push;
    logic                 beat;
    logic                 last_slice;
    logic                 pop;
    logic [IN_WIDTH-1:0]  head_data;
    logic [CNT_W-1:0]     fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [OUT_WIDTH-1:0] slice_mux;

    word_fifo #(
        .WIDTH (IN_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_word_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (din),
        .pop       (pop),
        .head_data (head_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rdy_upward = started_q && !fifo_full;
    assign vld_out    = started_q && !fifo_empty;

    assign push       = vld_in && rdy_upward;
    assign beat       = vld_out && rdy_downward;
    assign last_slice = (slice_q == SLICE_W'(R - 1));
    // The head word leaves only with its final beat.
    assign pop        = beat && last_slice;

    always_comb begin
        started_d = started_q || ap_start;
        slice_d   = slice_q;
        if (beat) begin
            slice_d = last_slice ? '0 : slice_q + SLICE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            started_q <= 1'b0;
            slice_q   <= '0;
        end else begin
            started_q <= started_d;
            slice_q   <= slice_d;
        end
    end

    // Constant-index mux keeps every part-select in range for any R.
    always_comb begin
        slice_mux = '0;
        for (int i = 0; i < R; i++) begin
            if (slice_q == SLICE_W'(i)) begin
                slice_mux = head_data[i*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    // An empty buffer drives zeros rather than stale storage contents.
    assign dout = (fifo_count == '0) ? '0 : slice_mux;

endmodule

// File: tb/tb_write_queue.sv
// tb_write_queue
//   Directed bench for write_queue (128 -> 32 bits, depth 2).
module tb_write_queue;

    localparam int IN_W  = 128;
    localparam int OUT_W = 32;
    localparam int DEPTH = 2;
    localparam int R     = IN_W / OUT_W;

    logic             clk;
    logic             reset;
    logic [IN_W-1:0]  din;
    logic             vld_in;
    logic             rdy_upward;
    logic [OUT_W-1:0] dout;
    logic             vld_out;
    logic             rdy_downward;
    logic             ap_start;

    int n_checks;
    int n_errors;

    logic [OUT_W-1:0] exp_q[$];
    logic [IN_W-1:0]  pend_q[$];

    write_queue #(
        .IN_WIDTH   (IN_W),
        .OUT_WIDTH  (OUT_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .din          (din),
        .vld_in       (vld_in),
        .rdy_upward   (rdy_upward),
        .dout         (dout),
        .vld_out      (vld_out),
        .rdy_downward (rdy_downward),
        .ap_start     (ap_start)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives pend_q words upstream and checks every cycle against exp_q.
    // Bit c of rdy_pat / vld_pat gives rdy_downward / vld_in permission in
    // loop cycle c (cycles past 31 use 1). Stops when both queues drain or
    // after max_iter cycles.
    task automatic run(input int max_iter, input logic [31:0] rdy_pat,
                       input logic [31:0] vld_pat, input bit expect_done);
        bit push_now;
        bit pop_now;
        int cyc;
        int words;
        logic [IN_W-1:0] w;
        push_now = 0;
        pop_now  = 0;
        cyc      = 0;
        forever begin
            @(negedge clk);
            if (pop_now) void'(exp_q.pop_front());
            if (push_now) begin
                w = pend_q.pop_front();
                for (int r = 0; r < R; r++) exp_q.push_back(w[r*OUT_W +: OUT_W]);
            end
            push_now = 0;
            pop_now  = 0;
            words = (exp_q.size() + R - 1) / R;
            check_eq("vld_out", vld_out, exp_q.size() != 0);
            check_eq("dout", dout, (exp_q.size() != 0) ? exp_q[0] : '0);
            check_eq("rdy_upward", rdy_upward, words < DEPTH);
            if ((pend_q.size() == 0 && exp_q.size() == 0) || cyc == max_iter) begin
                vld_in       = 1'b0;
                rdy_downward = 1'b0;
                break;
            end
            rdy_downward = (cyc < 32) ? rdy_pat[cyc] : 1'b1;
            vld_in       = (pend_q.size() != 0) && ((cyc < 32) ? vld_pat[cyc] : 1'b1);
            din          = vld_in ? pend_q[0] : '0;
            push_now     = vld_in && (words < DEPTH);
            pop_now      = rdy_downward && (exp_q.size() != 0);
            cyc++;
        end
        if (expect_done) begin
            check_eq("drain_done", exp_q.size() + pend_q.size(), 0);
        end
    endtask

    task automatic start_pulse();
        @(negedge clk);
        check_eq("rdy_before_start", rdy_upward, 1'b0);
        ap_start = 1'b1;
        @(negedge clk);
        check_eq("rdy_after_start", rdy_upward, 1'b1);
        ap_start = 1'b0;
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        reset        = 1'b1;
        din          = '0;
        vld_in       = 1'b0;
        rdy_downward = 1'b0;
        ap_start     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_rdy", rdy_upward, 1'b0);
        check_eq("reset_vld", vld_out, 1'b0);
        check_eq("reset_dout", dout, '0);
        reset = 1'b0;

        // Without ap_start nothing is accepted or emitted.
        for (int i = 0; i < 20; i++) begin
            din          = {$urandom_range(0, 32'hFFFF_FFFF), $urandom_range(0, 32'hFFFF_FFFF),
                            $urandom_range(0, 32'hFFFF_FFFF), $urandom_range(0, 32'hFFFF_FFFF)};
            vld_in       = 1'b1;
            rdy_downward = 1'b1;
            @(negedge clk);
            check_eq("idle_rdy", rdy_upward, 1'b0);
            check_eq("idle_vld", vld_out, 1'b0);
            check_eq("idle_dout", dout, '0);
        end
        vld_in       = 1'b0;
        rdy_downward = 1'b0;

        // Single word, full-rate drain: beats 1,2,3,4 then idle.
        start_pulse();
        pend_q.push_back(128'h00000004_00000003_00000002_00000001);
        run(100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);

        // Three words against a stalled leaf, then release.
        pend_q.push_back(128'h10000004_10000003_10000002_10000001);
        pend_q.push_back(128'h20000004_20000003_20000002_20000001);
        pend_q.push_back(128'h30000004_30000003_30000002_30000001);
        run(200, 32'hFFFF_FFC0, 32'hFFFF_FFFF, 1);

        // Leaf ready toggling 1,0,1,0 on one word.
        pend_q.push_back(128'h4444DDDD_4444CCCC_4444BBBB_4444AAAA);
        run(200, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 1);

        // Second word pushed in the same cycle as the first word's final beat.
        pend_q.push_back(128'h50000004_50000003_50000002_50000001);
        pend_q.push_back(128'h60000004_60000003_60000002_60000001);
        run(200, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1);

        // Reset after two beats of a word discards the rest of it.
        pend_q.push_back(128'h00000044_00000033_00000022_00000011);
        run(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_eq("async_reset_vld", vld_out, 1'b0);
        check_eq("async_reset_dout", dout, '0);
        check_eq("async_reset_rdy", rdy_upward, 1'b0);
        exp_q.delete();
        pend_q.delete();
        @(negedge clk);
        reset = 1'b0;
        din    = 128'h0000000D_0000000C_0000000B_0000000A;
        vld_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("post_reset_rdy", rdy_upward, 1'b0);
            check_eq("post_reset_vld", vld_out, 1'b0);
        end
        vld_in = 1'b0;
        start_pulse();
        pend_q.push_back(128'h0000000D_0000000C_0000000B_0000000A);
        run(100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
